// File: rtl/dcm_reset_sequencer.sv
// Reset/lock sequencer for two cascaded DCM stages (A = multiplier, B = phase stage).
// Releases B only after A shows a stable lock, retries on loss or timeout, and goes to FAULT when retries run out.
module dcm_reset_sequencer #(
  parameter int RST_HOLD_CYCLES = 4,
  parameter int STABLE_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter int MAX_RETRIES     = 3,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lockedA,
  input  logic       lockedB,
  output logic       dcmRstA,
  output logic       dcmRstB,
  output logic       clkLocked,
  output logic       sysRst,
  output logic       fault,
  output logic [2:0] retryCount,
  output logic [2:0] state
);

  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(STABLE_CYCLES - 1);
  localparam logic [STB_W-1:0] STABLE_MAX   = STB_W'(STABLE_CYCLES);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RST_A  = 3'd0,
    WAIT_A = 3'd1,
    RST_B  = 3'd2,
    WAIT_B = 3'd3,
    RUN    = 3'd4,
    FAULT  = 3'd5
  } stateT;

  stateT            fsmState;
  stateT            stateNext;
  logic             lkAMeta;
  logic             lkA;
  logic             lkBMeta;
  logic             lkB;
  logic [CNT_W-1:0] cnt;
  logic [STB_W-1:0] stableCnt;
  logic [2:0]       retryInc;
  logic             holdDone;
  logic             timedOut;
  logic             failAttempt;
  logic             watchedLock;

  always_comb begin
    holdDone    = (cnt == HOLD_LAST);
    timedOut    = (cnt == TIMEOUT_LAST);
    retryInc    = (retryCount == 3'd7) ? 3'd7 : retryCount + 3'd1;
    failAttempt = 1'b0;
    watchedLock = 1'b0;
    stateNext   = fsmState;
    case (fsmState)
      RST_A: begin
        if (holdDone) stateNext = WAIT_A;
      end
      WAIT_A: begin
        watchedLock = lkA;
        // Acceptance is checked before the timeout so a tie resolves to acceptance.
        if (lkA && stableCnt == STABLE_LAST) stateNext = RST_B;
        else if (timedOut)                   failAttempt = 1'b1;
      end
      RST_B: begin
        if (!lkA)          failAttempt = 1'b1;
        else if (holdDone) stateNext = WAIT_B;
      end
      WAIT_B: begin
        watchedLock = lkB;
        if (lkA && lkB && stableCnt == STABLE_LAST) stateNext = RUN;
        else if (!lkA || timedOut)                  failAttempt = 1'b1;
      end
      RUN: begin
        if (!lkA || !lkB) stateNext = RST_A;
      end
      FAULT: begin
        stateNext = FAULT;
      end
      default: begin
        stateNext = RST_A;
      end
    endcase
    if (failAttempt) stateNext = (retryInc == RETRY_LIMIT) ? FAULT : RST_A;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lkAMeta    <= 1'b0;
      lkA        <= 1'b0;
      lkBMeta    <= 1'b0;
      lkB        <= 1'b0;
      fsmState   <= RST_A;
      cnt        <= '0;
      stableCnt  <= '0;
      retryCount <= 3'd0;
      dcmRstA    <= 1'b1;
      dcmRstB    <= 1'b1;
      clkLocked  <= 1'b0;
      sysRst     <= 1'b1;
      fault      <= 1'b0;
    end else begin
      lkAMeta  <= lockedA;
      lkA      <= lkAMeta;
      lkBMeta  <= lockedB;
      lkB      <= lkBMeta;
      fsmState <= stateNext;

      // Shared hold/timeout counter is parked in the terminal states so it never wraps.
      if (stateNext != fsmState || fsmState == RUN || fsmState == FAULT) cnt <= '0;
      else                                                                cnt <= cnt + 1'b1;

      if (stateNext != fsmState || !watchedLock) stableCnt <= '0;
      else if (stableCnt != STABLE_MAX)          stableCnt <= stableCnt + 1'b1;

      if (failAttempt)                              retryCount <= retryInc;
      else if (stateNext == RUN && fsmState != RUN) retryCount <= 3'd0;

      // Outputs decode the next state so they change on the same edge as the FSM.
      dcmRstA   <= (stateNext == RST_A) || (stateNext == FAULT);
      dcmRstB   <= (stateNext != WAIT_B) && (stateNext != RUN);
      clkLocked <= (stateNext == RUN);
      sysRst    <= (stateNext != RUN);
      fault     <= (stateNext == FAULT);
    end
  end

  assign state = fsmState;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Directed bench for dcm_reset_sequencer: vector table for bring-up and lock loss,
// hand-written sequences for retries, timeout to FAULT, glitchy lock and asynchronous reset.
module tb_dcm_reset_sequencer;

  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lockedA = 1'b0;
  logic       lockedB = 1'b0;
  logic       dcmRstA;
  logic       dcmRstB;
  logic       clkLocked;
  logic       sysRst;
  logic       fault;
  logic [2:0] retryCount;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  dcm_reset_sequencer #(
    .RST_HOLD_CYCLES(4),
    .STABLE_CYCLES(16),
    .TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRIES(3),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lockedA(lockedA),
    .lockedB(lockedB),
    .dcmRstA(dcmRstA),
    .dcmRstB(dcmRstB),
    .clkLocked(clkLocked),
    .sysRst(sysRst),
    .fault(fault),
    .retryCount(retryCount),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, state=%0d", state);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       la;
    logic       lb;
    int         n;
    logic [2:0] st;
    logic       rA;
    logic       rB;
    logic       cl;
    logic       sr;
    logic       f;
    logic [2:0] rc;
  } vecT;

  vecT vecs[20];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Packed as {state, dcmRstA, dcmRstB, clkLocked, sysRst, fault, retryCount}.
  task automatic checkOuts(input string name, input logic [2:0] st, input logic rA, input logic rB,
                           input logic cl, input logic sr, input logic f, input logic [2:0] rc);
    check(name, {21'd0, state, dcmRstA, dcmRstB, clkLocked, sysRst, fault, retryCount},
                {21'd0, st, rA, rB, cl, sr, f, rc});
  endtask

  task automatic waitState(input string name, input logic [2:0] target, input int budget);
    int i = 0;
    while (state !== target && i < budget) begin
      tick(1);
      i++;
    end
    total++;
    if (state !== target) begin
      bad++;
      $display("FAIL %s: state=%0d want=%0d after %0d cycles", name, state, target, i);
    end
  endtask

  // Leaves rst deasserted just after a rising edge; that edge is cycle 0 of the sequence.
  task automatic doReset();
    rst = 1'b1;
    lockedA = 1'b0;
    lockedB = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  initial begin
    int maxStable;
    bit sawRstB;

    //        la    lb    n   st    rA    rB    cl    sr    f     rc
    vecs[0]  = '{1'b0, 1'b0, 3,  3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 1,  3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 6,  3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[3]  = '{1'b1, 1'b0, 17, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[4]  = '{1'b1, 1'b0, 1,  3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[5]  = '{1'b1, 1'b0, 3,  3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[6]  = '{1'b1, 1'b0, 1,  3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[7]  = '{1'b1, 1'b0, 10, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[8]  = '{1'b1, 1'b1, 17, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[9]  = '{1'b1, 1'b1, 1,  3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{1'b1, 1'b1, 20, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[11] = '{1'b1, 1'b0, 2,  3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[12] = '{1'b1, 1'b0, 1,  3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[13] = '{1'b1, 1'b1, 3,  3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[14] = '{1'b1, 1'b1, 1,  3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[15] = '{1'b1, 1'b1, 15, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[16] = '{1'b1, 1'b1, 1,  3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[17] = '{1'b1, 1'b1, 4,  3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[18] = '{1'b1, 1'b1, 15, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[19] = '{1'b1, 1'b1, 1,  3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};

    // Reset state while rst is held.
    tick(2);
    checkOuts("reset_values", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);

    // Nominal bring-up, lock loss in RUN (lockedB low 3 cycles), and full re-sequence.
    rst = 1'b0;
    for (int v = 0; v < 20; v++) begin
      lockedA = vecs[v].la;
      lockedB = vecs[v].lb;
      tick(vecs[v].n);
      $display("vec %0d: la=%0b lb=%0b state=%0d rstA=%0b rstB=%0b locked=%0b retry=%0d",
               v, vecs[v].la, vecs[v].lb, state, dcmRstA, dcmRstB, clkLocked, retryCount);
      checkOuts($sformatf("vec%0d", v), vecs[v].st, vecs[v].rA, vecs[v].rB,
                vecs[v].cl, vecs[v].sr, vecs[v].f, vecs[v].rc);
    end

    // lockedA lost during WAIT_B counts as a failed attempt; a clean lock then clears retryCount.
    lockedA = 1'b0;
    tick(3);
    checkOuts("runLossA", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    lockedA = 1'b1;
    lockedB = 1'b0;
    waitState("reachWaitB1", 3'd3, 100);
    lockedA = 1'b0;
    tick(2);
    checkOuts("waitBbeforeFail", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    tick(1);
    checkOuts("waitBfail", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    $display("seq waitB lossA: state=%0d retry=%0d", state, retryCount);
    lockedA = 1'b1;
    lockedB = 1'b1;
    waitState("relock", 3'd4, 200);
    checkOuts("relockRun", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    $display("seq relock: state=%0d retry=%0d", state, retryCount);

    // Asynchronous rst mid-WAIT_B with a non-zero retryCount.
    lockedB = 1'b0;
    waitState("dropB", 3'd0, 10);
    waitState("reachWaitB2", 3'd3, 100);
    lockedA = 1'b0;
    tick(3);
    lockedA = 1'b1;
    waitState("reachWaitB3", 3'd3, 100);
    tick(5);
    checkOuts("preAsyncRst", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    #3 rst = 1'b1;
    #1;
    checkOuts("asyncRst", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    $display("seq async rst: state=%0d rstA=%0b rstB=%0b", state, dcmRstA, dcmRstB);
    tick(2);
    checkOuts("asyncRstHeld", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);

    // Stage A never locks: three 204-cycle attempts, then sticky FAULT.
    doReset();
    tick(203);
    checkOuts("to1wait", 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    tick(1);
    checkOuts("to1fail", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    tick(203);
    checkOuts("to2wait", 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    tick(1);
    checkOuts("to2fail", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    tick(203);
    checkOuts("to3wait", 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    tick(1);
    checkOuts("faultEntry", 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3);
    lockedA = 1'b1;
    lockedB = 1'b1;
    tick(30);
    checkOuts("faultSticky", 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3);
    $display("seq timeout: state=%0d fault=%0b retry=%0d", state, fault, retryCount);

    // Glitchy lockedA: 10 high / 1 low must never be accepted.
    doReset();
    tick(4);
    checkOuts("glitchWaitA", 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    maxStable = 0;
    sawRstB = 1'b0;
    for (int p = 0; p < 6; p++) begin
      lockedA = 1'b1;
      for (int c = 0; c < 11; c++) begin
        if (c == 10) lockedA = 1'b0;
        tick(1);
        if (int'(dut.stableCnt) > maxStable) maxStable = int'(dut.stableCnt);
        if (state == 3'd2) sawRstB = 1'b1;
      end
    end
    check("glitchNoRstB", {31'd0, sawRstB}, 32'd0);
    check("glitchStableMax", maxStable, 32'd10);
    lockedA = 1'b1;
    tick(17);
    checkOuts("steadyWaitA", 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    tick(1);
    checkOuts("steadyRstB", 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    $display("seq glitch: maxStable=%0d state=%0d", maxStable, state);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
